// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter fetch front end.
package pc_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam int              PC_AW           = 32;
  localparam logic [PC_AW-1:0] PC_RESET_VECTOR = '0;
  localparam int              PC_STEP         = 4;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with flush; the head reads as zero while empty.
module sync_fifo #(
  parameter int  W     = 8,
  parameter int  DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Flush wins over a same-cycle push or pop: the queue restarts empty.
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push & ~full & ~flush;
  assign do_pop   = pop & ~empty & ~flush;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch front end: issues sequential fetches, tracks them
// in flight, pairs responses with their PC and buffers them for decode.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int            AW           = PC_AW,
  parameter logic [AW-1:0] RESET_VECTOR = AW'(PC_RESET_VECTOR),
  parameter int            STEP         = PC_STEP,
  parameter int            IW           = 32,
  parameter int            DEPTH        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halt_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic          req_o,
  output logic [AW-1:0] req_addr_o,
  input  logic          req_ready_i,
  input  logic          rsp_valid_i,
  input  logic [IW-1:0] rsp_data_i,
  output logic          inst_valid_o,
  output logic [AW-1:0] inst_pc_o,
  output logic [IW-1:0] inst_o,
  input  logic          inst_ready_i,
  output pc_state_e     state_o
);

  // Handshakes: a transfer happens on every clock edge where valid and ready
  // are both high; valid never depends on ready, and the offered address
  // stays put until it is taken. Responses carry no ready and are in order.

  localparam int            CW         = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] STEP_V     = AW'(STEP);
  localparam logic [AW-1:0] ALIGN_MASK = ~(STEP_V - AW'(1));

  pc_state_e        state_q;
  pc_state_e        state_d;
  logic [AW-1:0]    pc_q;
  logic [AW-1:0]    pc_d;
  logic [CW-1:0]    inflight_cnt;
  logic [CW-1:0]    buffered_cnt;
  logic [CW-1:0]    drop_cnt;
  logic [CW:0]      occupancy;
  logic             pc_empty;
  logic             out_empty;
  logic             req_fire;
  logic             rsp_pop;
  logic             rsp_keep;
  logic             inst_pop;
  logic [AW-1:0]    rsp_pc;
  logic [AW+IW-1:0] out_head;

  // Every issued fetch reserves a buffer slot, so the output FIFO cannot overflow.
  assign occupancy  = {1'b0, inflight_cnt} + {1'b0, buffered_cnt};
  assign req_o      = (state_q == RUN) & ~halt_i & ~redirect_i
                    & (occupancy < (CW+1)'(DEPTH));
  assign req_addr_o = pc_q;
  assign req_fire   = req_o & req_ready_i;

  assign rsp_pop    = rsp_valid_i & ~pc_empty;
  assign rsp_keep   = rsp_pop & ~redirect_i & (drop_cnt == '0);

  assign inst_valid_o = ~out_empty;
  assign inst_pop     = ~out_empty & inst_ready_i;
  assign inst_pc_o    = out_head[AW+IW-1:IW];
  assign inst_o       = out_head[IW-1:0];
  assign state_o      = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT:    state_d = RUN;
      RUN:     if (halt_i)  state_d = HALTED;
      HALTED:  if (!halt_i) state_d = RUN;
      default: state_d = WAIT;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_i)    pc_d = redirect_pc_i & ALIGN_MASK;
    else if (req_fire) pc_d = pc_q + STEP_V;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // A redirect marks everything still in flight after this edge as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (redirect_i) begin
      drop_cnt <= inflight_cnt - CW'(rsp_pop);
    end else if (rsp_pop && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  sync_fifo #(
    .W     (AW),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_pop),
    .pop_data  (rsp_pc),
    .empty     (pc_empty),
    .count     (inflight_cnt)
  );

  sync_fifo #(
    .W     (AW + IW),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (rsp_keep),
    .push_data ({rsp_pc, rsp_data_i}),
    .pop       (inst_pop),
    .pop_data  (out_head),
    .empty     (out_empty),
    .count     (buffered_cnt)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed tables and sequences plus a random run
// against a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_pc_fetch_unit;
  import pc_pkg::*;

  localparam int            AW    = 32;
  localparam int            IW    = 32;
  localparam int            DEPTH = 4;
  localparam int            STEP  = 4;
  localparam logic [AW-1:0] RV    = 32'h0000_0000;
  localparam logic [AW-1:0] RV2   = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          halt_i, redirect_i, req_ready_i, rsp_valid_i, inst_ready_i;
  logic [AW-1:0] redirect_pc_i;
  logic [IW-1:0] rsp_data_i;
  logic          req_o, inst_valid_o;
  logic [AW-1:0] req_addr_o, inst_pc_o;
  logic [IW-1:0] inst_o;
  pc_state_e     state_o;

  pc_fetch_unit #(.AW(AW), .RESET_VECTOR(RV), .STEP(STEP), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .halt_i(halt_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .req_o(req_o), .req_addr_o(req_addr_o),
    .req_ready_i(req_ready_i), .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .inst_valid_o(inst_valid_o), .inst_pc_o(inst_pc_o), .inst_o(inst_o),
    .inst_ready_i(inst_ready_i), .state_o(state_o)
  );

  // Second instance: top-of-memory reset vector, memory never answers.
  logic          w_req_o, w_inst_valid_o;
  logic [AW-1:0] w_req_addr_o, w_inst_pc_o;
  logic [IW-1:0] w_inst_o;
  pc_state_e     w_state_o;
  logic [AW-1:0] w_addrs[$];

  pc_fetch_unit #(.AW(AW), .RESET_VECTOR(RV2), .STEP(STEP), .IW(IW), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n), .halt_i(1'b0), .redirect_i(1'b0),
    .redirect_pc_i('0), .req_o(w_req_o), .req_addr_o(w_req_addr_o),
    .req_ready_i(1'b1), .rsp_valid_i(1'b0), .rsp_data_i('0),
    .inst_valid_o(w_inst_valid_o), .inst_pc_o(w_inst_pc_o), .inst_o(w_inst_o),
    .inst_ready_i(1'b0), .state_o(w_state_o)
  );

  always @(negedge clk) if (rst_n && w_req_o) w_addrs.push_back(w_req_addr_o);

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    int            epoch;
  } flight_t;

  flight_t             mem_q[$];   // fetches accepted by memory, oldest first
  logic [AW+IW-1:0]    exp_q[$];   // {pc, inst} decode should see, oldest first
  logic [AW-1:0]       exp_req_pc;
  int                  epoch;
  bit                  started, prev_halt, prev_redirect;
  int                  rsp_pct;
  int                  checks = 0;
  int                  failures = 0;

  logic          cap_req_fire, cap_rsp_fire, cap_pop_fire;
  logic [AW-1:0] cap_req_addr;

  function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_settle();
    rsp_valid_i = (mem_q.size() > 0) && ($urandom_range(99) < rsp_pct);
    rsp_data_i  = rsp_valid_i ? mem_data(mem_q[0].addr) : '0;
    #1;
    assert (!(rsp_valid_i && mem_q.size() == 0)) else $error("protocol: response with none in flight");
    assert (!(redirect_i && prev_redirect)) else $error("protocol: redirect held over two cycles");
    chk("req_o", req_o, started && !prev_halt && !halt_i && !redirect_i
                        && (mem_q.size() + exp_q.size() < DEPTH));
    chk("req_addr", req_addr_o, exp_req_pc);
    chk("inst_valid", inst_valid_o, exp_q.size() > 0);
    if (inst_valid_o && exp_q.size() > 0) chk("inst_head", {inst_pc_o, inst_o}, exp_q[0]);
    cap_req_fire = req_o & req_ready_i;
    cap_req_addr = req_addr_o;
    cap_rsp_fire = rsp_valid_i;
    cap_pop_fire = inst_valid_o & inst_ready_i;
  endtask

  task automatic step_edge();
    flight_t f;
    @(posedge clk);
    if (!started) begin
      started   = 1'b1;
      prev_halt = 1'b0;
    end else begin
      prev_halt = halt_i;
    end
    prev_redirect = redirect_i;
    if (cap_req_fire) begin
      mem_q.push_back('{addr: cap_req_addr, epoch: epoch});
      exp_req_pc = exp_req_pc + AW'(STEP);
    end
    if (cap_rsp_fire) f = mem_q.pop_front();
    if (redirect_i) begin
      epoch++;
      exp_q.delete();
      exp_req_pc = redirect_pc_i & ~AW'(STEP - 1);
    end else begin
      if (cap_pop_fire && exp_q.size() > 0) void'(exp_q.pop_front());
      if (cap_rsp_fire && f.epoch == epoch) exp_q.push_back({f.addr, mem_data(f.addr)});
    end
    @(negedge clk);
  endtask

  task automatic set_inputs(input bit halt, input bit rdy, input bit iready, input int pct);
    halt_i = halt; redirect_i = 1'b0; req_ready_i = rdy; inst_ready_i = iready; rsp_pct = pct;
  endtask

  // Asserted mid-cycle to exercise the asynchronous path; released on a falling edge.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    halt_i = 1'b0; redirect_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = '0;
    inst_ready_i = 1'b0; req_ready_i = 1'b0; redirect_pc_i = '0;
    #1;
    chk("rst_req_o", req_o, 1'b0);
    chk("rst_req_addr", req_addr_o, RV);
    chk("rst_inst_valid", inst_valid_o, 1'b0);
    chk("rst_inst_pc", inst_pc_o, '0);
    chk("rst_inst", inst_o, '0);
    chk("rst_state", state_o, WAIT);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_q.delete(); exp_q.delete();
    exp_req_pc = RV; epoch++; started = 1'b0; prev_halt = 1'b0; prev_redirect = 1'b0;
  endtask

  // Streaming with a one-cycle memory right after reset release.
  task automatic check_stream(input string tag);
    set_inputs(1'b0, 1'b1, 1'b1, 100);
    for (int c = 0; c < 10; c++) begin
      step_settle();
      chk({tag, "_req"}, req_o, c >= 1);
      if (c >= 1) chk({tag, "_addr"}, req_addr_o, 4 * (c - 1));
      chk({tag, "_valid"}, inst_valid_o, c >= 3);
      if (c >= 3) chk({tag, "_pc"}, inst_pc_o, 4 * (c - 3));
      step_edge();
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          inst_ready;
    logic          exp_req;
    logic [AW-1:0] exp_addr;
    logic          exp_valid;
    logic [AW-1:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    bit   found, last_redir;
    int   cnt;
    vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[3]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[4]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    vecs[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    vecs[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    vecs[7]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
    vecs[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
    vecs[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    vecs[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    vecs[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

    epoch = 0; rsp_pct = 0;
    @(negedge clk);
    apply_reset();

    // Decode stalled: fill to DEPTH, then drain in order and resume at 0x10.
    for (int i = 0; i < 12; i++) begin
      set_inputs(1'b0, 1'b1, vecs[i].inst_ready, 100);
      step_settle();
      chk($sformatf("tbl%0d_req", i), req_o, vecs[i].exp_req);
      chk($sformatf("tbl%0d_addr", i), req_addr_o, vecs[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), inst_valid_o, vecs[i].exp_valid);
      chk($sformatf("tbl%0d_pc", i), inst_pc_o, vecs[i].exp_pc);
      step_edge();
    end

    // Wrap from the top of the address space.
    chk("wrap_count", w_addrs.size() >= 3, 1'b1);
    if (w_addrs.size() >= 3) begin
      chk("wrap_a0", w_addrs[0], 32'hFFFF_FFF8);
      chk("wrap_a1", w_addrs[1], 32'hFFFF_FFFC);
      chk("wrap_a2", w_addrs[2], 32'h0000_0000);
    end
    chk("wrap_inst_valid", w_inst_valid_o, 1'b0);

    apply_reset();
    check_stream("stream");

    // Redirect with three fetches outstanding.
    apply_reset();
    set_inputs(1'b0, 1'b1, 1'b0, 0);
    repeat (4) begin step_settle(); step_edge(); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_1003;
    step_settle(); step_edge();
    redirect_i = 1'b0;
    step_settle();
    chk("redir_addr", req_addr_o, 32'h0000_1000);
    step_edge();
    set_inputs(1'b0, 1'b1, 1'b1, 100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step_settle();
      if (inst_valid_o) begin
        found = 1'b1;
        chk("redir_first_pc", inst_pc_o, 32'h0000_1000);
      end
      step_edge();
    end
    chk("redir_timeout", found, 1'b1);

    // Halt at PC 0x20 for five cycles.
    apply_reset();
    set_inputs(1'b0, 1'b1, 1'b1, 100);
    for (int k = 0; k < 30 && exp_req_pc != 32'h20; k++) begin step_settle(); step_edge(); end
    chk("halt_reach", exp_req_pc, 32'h20);
    halt_i = 1'b1;
    cnt = 0;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step_settle();
      if (req_o) found = 1'b1;
      if (cap_pop_fire) cnt++;
      step_edge();
    end
    chk("halt_no_req", found, 1'b0);
    chk("halt_drain", cnt, 2);
    halt_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step_settle();
      if (cap_req_fire) begin
        found = 1'b1;
        chk("halt_resume_addr", cap_req_addr, 32'h20);
      end
      step_edge();
    end
    chk("halt_resume_timeout", found, 1'b1);

    // Reset with two fetches in flight and two buffered.
    apply_reset();
    set_inputs(1'b0, 1'b1, 1'b0, 100);
    repeat (4) begin step_settle(); step_edge(); end
    rsp_pct = 0;
    step_settle(); step_edge();
    chk("midrst_inflight", mem_q.size(), 2);
    chk("midrst_valid_before", inst_valid_o, 1'b1);
    apply_reset();
    check_stream("restart");

    // Random traffic against the model.
    apply_reset();
    set_inputs(1'b0, 1'b1, 1'b1, 50);
    last_redir = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      req_ready_i  = ($urandom_range(99) < 70);
      inst_ready_i = ($urandom_range(99) < 60);
      rsp_pct      = 50;
      if ($urandom_range(99) < 5) halt_i = ~halt_i;
      redirect_i    = !last_redir && !halt_i && ($urandom_range(99) < 3);
      redirect_pc_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                               : 32'($urandom);
      last_redir = redirect_i;
      step_settle();
      step_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter and fetch front end. It generates sequential fetch addresses, issues them to instruction memory over a ready/valid request channel, and tracks up to DEPTH outstanding fetches. Returned instructions are paired with their PC and buffered for the decode stage. Redirects flush the buffer and drop stale responses; halt pauses fetching with the PC held, and fetching resumes from that PC on release.

## Interface
- AW, 32: address width.
- RESET_VECTOR, 0: PC after reset (AW bits).
- STEP, 4: PC increment per fetch; power of 2.
- IW, 32: instruction width.
- DEPTH, 4: max (in-flight + buffered) fetches; power of 2, ≥2.

- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- halt_i  in  1  level; stop issuing new fetches.
- redirect_i  in  1  single-cycle pulse; load redirect_pc_i, flush.
- redirect_pc_i  in  AW  redirect target.
- req_o  out  1  fetch request valid.
- req_addr_o  out  AW  fetch address (= current PC).
- req_ready_i  in  1  memory accepts request.
- rsp_valid_i  in  1  in-order response valid; no backpressure.
- rsp_data_i  in  IW  fetched instruction.
- inst_valid_o  out  1  buffered instruction available.
- inst_pc_o  out  AW  PC of head instruction.
- inst_o  out  IW  head instruction.
- inst_ready_i  in  1  decode consumes head.

## Operation
- FSM states:
  - WAIT: entered on reset; lasts exactly one clock; no fetch.
  - RUN: WAIT → RUN unconditionally.
  - HALTED: RUN → HALTED when halt_i=1 is sampled; HALTED → RUN when halt_i=0 is sampled.
- req_o = (state==RUN) & !halt_i & !redirect_i & (inflight + buffered < DEPTH).
- Request handshake: accepted on req_o & req_ready_i. PC advances by STEP modulo 2^AW; 2^AW−STEP wraps to 0. The accepted PC is pushed to the in-flight PC FIFO.
- Request stability: req_addr_o holds while req_o=1 and req_ready_i=0.
- Response, not dropping: pop the PC FIFO head and push {pc, rsp_data_i} to the output FIFO.
- Response, drop_cnt>0: pop the PC FIFO, decrement drop_cnt, discard the data.
- Redirect:
  - PC ← redirect_pc_i with log2(STEP) LSBs forced to 0.
  - Output FIFO is flushed.
  - drop_cnt ← in-flight count after this cycle. A response arriving in the redirect cycle is itself discarded.
  - Redirect overrides halt and a simultaneous request, which is not issued. It is legal in any state and does not change state.
- Halt: PC is held. In-flight responses complete and are buffered normally. The output FIFO keeps draining.
- Output FIFO is show-ahead: inst_valid_o = not empty. Pop on inst_valid_o & inst_ready_i.
- Credit rule: the output FIFO can never overflow because of the DEPTH limit on req_o.
- Protocol violations: rsp_valid_i with zero in flight, or redirect_i held for more than one cycle, are illegal. A bench assertion flags them.
- Reset mid-operation: all FIFOs and drop_cnt are cleared immediately; PC ← RESET_VECTOR; state → WAIT. Outstanding memory responses after reset are the system's responsibility.

## Timing
- Reset values:
  - req_o=0, req_addr_o=RESET_VECTOR.
  - inst_valid_o=0, inst_pc_o=0, inst_o=0.
  - drop_cnt=0, state=WAIT.
- req_o is first asserted in the second cycle after rst_n deasserts.
- req_o is combinational from state and counters, plus halt_i/redirect_i.
- Response latency: response in cycle M → inst_valid_o in M+1.
- Full-throughput streaming is possible with DEPTH ≥2 and single-cycle memory.
- Halt: halt_i sampled high in cycle N suppresses req_o in N combinationally. Deassertion re-enables req_o from N+1 (HALTED→RUN takes one edge).
- Redirect in cycle N:
  - req_addr_o = new PC in N+1.
  - inst_valid_o=0 in N+1 unless a non-dropped response was pushed in N+1.

## Structure
- Package pc_pkg:
  - FSM state enum {WAIT, RUN, HALTED}.
  - Default constants: PC_AW=32, PC_RESET_VECTOR, PC_STEP=4.
- Sub-module sync_fifo (parameters W, DEPTH; flush input; show-ahead), instantiated twice:
  - In-flight PC FIFO, W=AW.
  - Output FIFO, W=AW+IW.
- Top level holds the PC register, FSM, in-flight/buffered counters and drop_cnt.

## Test plan
- Reset release, req_ready_i=1, 1-cycle memory → first req in cycle 2 at 0x0; addresses 0x0,0x4,0x8… each cycle; inst_pc_o follows one cycle after each response.
- inst_ready_i=0, DEPTH=4, 1-cycle memory → exactly 4 requests accepted, then req_o=0; raising inst_ready_i drains 0x0..0xC in order and fetching resumes at 0x10.
- 3 fetches in flight, redirect to 0x1003 → next req_addr_o=0x1000; the 3 stale responses are dropped; first inst_pc_o=0x1000.
- halt_i high for 5 cycles at PC 0x20 → no requests during halt; in-flight instructions still delivered; next request after release at 0x20.
- RESET_VECTOR=0xFFFFFFF8, sequential fetch → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- rst_n asserted with 2 in flight and 2 buffered → inst_valid_o=0 immediately; req_addr_o=RESET_VECTOR; restart as in scenario 1.
